// File: rtl/intra_plane_seq_if.sv
// Handshake bundle between the MB intra controller / PE and the plane-prediction sequencer.
// master = controller + PE side, slave = sequencer.
interface intra_plane_seq_if;
   logic       start;
   logic       luma_plane;
   logic       chroma_plane;
   logic       pe_done;
   logic [3:0] precalc_counter;
   logic [4:0] blk4x4_counter;
   logic       abc_latch;
   logic       seed_latch;
   logic       seed_wr;
   logic       pe_start;
   logic       busy;
   logic       done;

   modport master (
      output start, luma_plane, chroma_plane, pe_done,
      input  precalc_counter, blk4x4_counter, abc_latch, seed_latch, seed_wr,
             pe_start, busy, done
   );

   modport slave (
      input  start, luma_plane, chroma_plane, pe_done,
      output precalc_counter, blk4x4_counter, abc_latch, seed_latch, seed_wr,
             pe_start, busy, done
   );
endinterface

// File: rtl/intra_plane_seq.sv
// Sequencer for the intra plane-prediction precalc pipeline and the 4x4 PE:
// walks luma blocks 0..15 and/or chroma Cb 16..19, Cr 20..23 one block at a time.
module intra_plane_seq #(
   parameter int LUMA_LEN   = 8,
   parameter int CHROMA_LEN = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   intra_plane_seq_if.slave   bus
);

   typedef enum logic [2:0] {IDLE, PRECALC, ABC, SEED, ISSUE, WAIT, WR, FIN} state_t;

   state_t     state;
   logic [3:0] pc;
   logic [4:0] blk;
   logic       chroma_q;
   logic       last_blk;

   // Last block of a plane group: no seed update follows it.
   assign last_blk = (blk == 5'd15) || (blk == 5'd19) || (blk == 5'd23);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pc       <= '0;
         blk      <= '0;
         chroma_q <= 1'b0;
      end else if (ena) begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  chroma_q <= bus.chroma_plane;
                  if (bus.luma_plane) begin
                     blk   <= 5'd0;
                     pc    <= 4'(LUMA_LEN);
                     state <= PRECALC;
                  end else if (bus.chroma_plane) begin
                     blk   <= 5'd16;
                     pc    <= 4'(CHROMA_LEN);
                     state <= PRECALC;
                  end else begin
                     state <= FIN;
                  end
               end
            end
            PRECALC: begin
               pc <= pc - 4'd1;
               if (pc <= 4'd1) begin
                  pc    <= '0;
                  state <= ABC;
               end
            end
            ABC:   state <= SEED;
            SEED:  state <= ISSUE;
            ISSUE: state <= WAIT;
            WAIT:  if (bus.pe_done) state <= WR;
            WR: begin
               case (blk)
                  5'd15: begin
                     if (chroma_q) begin
                        blk   <= 5'd16;
                        pc    <= 4'(CHROMA_LEN);
                        state <= PRECALC;
                     end else begin
                        state <= FIN;
                     end
                  end
                  5'd19: begin
                     blk   <= 5'd20;
                     pc    <= 4'(CHROMA_LEN);
                     state <= PRECALC;
                  end
                  5'd23:   state <= FIN;
                  default: begin
                     blk   <= blk + 5'd1;
                     state <= ISSUE;
                  end
               endcase
            end
            FIN: begin
               blk      <= '0;
               pc       <= '0;
               chroma_q <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Strobes are gated by ena so a stalled state never emits twice.
   assign bus.abc_latch       = ena && (state == ABC);
   assign bus.seed_latch      = ena && (state == SEED);
   assign bus.pe_start        = ena && (state == ISSUE);
   assign bus.seed_wr         = ena && (state == WR) && !last_blk;
   assign bus.done            = ena && (state == FIN);
   assign bus.busy            = (state != IDLE) && (state != FIN);
   assign bus.precalc_counter = pc;
   assign bus.blk4x4_counter  = blk;

endmodule

// File: tb/tb_intra_plane_seq.sv
// Directed bench for intra_plane_seq: luma/chroma/both runs, ena stall, spurious inputs, abort.
module tb_intra_plane_seq;

   logic clk;
   logic rst_n;
   logic ena;
   intra_plane_seq_if bus();

   intra_plane_seq #(.LUMA_LEN(8), .CHROMA_LEN(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   logic [14:0] tr[$];
   logic [14:0] ref_tr[$];
   int          pe_blks[$];
   int          n_pe, n_wr, n_abc, n_seed, n_done, wr_last, idle_strobe;
   bit          fin, aborted;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // {pe_start, seed_wr, seed_latch, abc_latch, done, busy, blk[4:0], pc[3:0]}
   function automatic logic [14:0] word();
      return {bus.pe_start, bus.seed_wr, bus.seed_latch, bus.abc_latch, bus.done,
              bus.busy, bus.blk4x4_counter, bus.precalc_counter};
   endfunction

   function automatic int order_err(input int base);
      int e = 0;
      foreach (pe_blks[i]) if (pe_blks[i] != base + i) e++;
      return e;
   endfunction

   function automatic int trace_diff();
      int e = 0;
      if (tr.size() != ref_tr.size()) return 9999;
      foreach (tr[i]) if (tr[i] !== ref_tr[i]) e++;
      return e;
   endfunction

   // One macroblock. PE model counts ena cycles only, so stalled runs compress to the same trace.
   task automatic run_mb(input logic l, input logic c, input bit tog, input bit hold,
                         input bit spur, input bit bstart, input bit abort);
      int lat = 0;
      bit armed = 0;
      logic [14:0] w;
      tr.delete(); pe_blks.delete();
      n_pe = 0; n_wr = 0; n_abc = 0; n_seed = 0; n_done = 0; wr_last = 0; idle_strobe = 0;
      fin = 0; aborted = 0;
      bus.pe_done = hold;
      @(posedge clk); #1;
      ena = 1'b1; bus.start = 1'b1; bus.luma_plane = l; bus.chroma_plane = c;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.luma_plane = 1'b0; bus.chroma_plane = 1'b0;
      for (int t = 0; t < 3000 && !fin && !aborted; t++) begin
         ena = tog ? (t % 2 == 1) : 1'b1;
         bus.start = bstart && (t == 20);
         bus.luma_plane = bus.start;
         bus.chroma_plane = bus.start;
         @(negedge clk);
         w = word();
         if (!ena && (|w[14:10])) idle_strobe++;
         if (ena && armed) begin
            rst_n = 1'b0;
            #1;
            chk("abort_outputs", int'(word()), 0);
            aborted = 1;
         end else if (ena) begin
            tr.push_back(w);
            if (bus.pe_start) begin n_pe++; pe_blks.push_back(int'(bus.blk4x4_counter)); end
            if (bus.seed_wr) begin
               n_wr++;
               if (bus.blk4x4_counter inside {5'd15, 5'd19, 5'd23}) wr_last++;
            end
            if (bus.abc_latch) n_abc++;
            if (bus.seed_latch) n_seed++;
            if (bus.done) begin n_done++; fin = 1; end
            if (!hold) begin
               if (bus.pe_done) bus.pe_done = 1'b0;
               if (bus.pe_start) lat = 2;
               else if (lat > 0) begin
                  lat--;
                  if (lat == 0) bus.pe_done = 1'b1;
               end
               if (spur && (bus.precalc_counter != 4'd0 || bus.pe_start)) bus.pe_done = 1'b1;
            end
            if (abort && bus.pe_start && bus.blk4x4_counter == 5'd7) armed = 1;
         end
         if (!aborted) begin @(posedge clk); #1; end
      end
      ena = 1'b1;
      bus.pe_done = 1'b0;
      bus.start = 1'b0;
      if (!abort) chk("run_completes", int'(fin), 1);
   endtask

   initial begin
      int first_pe;
      rst_n = 1'b0; ena = 1'b1;
      bus.start = 1'b1; bus.luma_plane = 1'b1; bus.chroma_plane = 1'b1; bus.pe_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", int'(word()), 0);
      bus.start = 1'b0; bus.luma_plane = 1'b0; bus.chroma_plane = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_after_reset", int'(word()), 0);

      // Luma only.
      run_mb(1'b1, 1'b0, 0, 0, 0, 0, 0);
      chk("luma_len", tr.size(), 75);
      for (int i = 0; i < 9; i++) chk("luma_precalc_cnt", int'(tr[i][3:0]), 8 - i);
      chk("luma_busy_first", int'(tr[0][9]), 1);
      chk("luma_abc_c9", int'(tr[8][11]), 1);
      chk("luma_seed_c10", int'(tr[9][12]), 1);
      first_pe = -1;
      foreach (tr[i]) if (first_pe < 0 && tr[i][14]) first_pe = i;
      chk("luma_first_pe_c11", first_pe + 1, 11);
      chk("luma_pe_cnt", n_pe, 16);
      chk("luma_pe_order", order_err(0), 0);
      chk("luma_wr_cnt", n_wr, 15);
      chk("luma_wr_on_last", wr_last, 0);
      chk("luma_done_cnt", n_done, 1);
      chk("luma_done_busy", int'(tr[tr.size()-1][9]), 0);
      chk("luma_end_blk", int'(bus.blk4x4_counter), 0);
      chk("luma_end_busy", int'(bus.busy), 0);

      // Chroma only.
      run_mb(1'b0, 1'b1, 0, 0, 0, 0, 0);
      chk("chroma_len", tr.size(), 45);
      chk("chroma_cb_pre", int'(tr[0][8:0]), (16 << 4) | 4);
      chk("chroma_cr_pre", int'(tr[22][8:0]), (20 << 4) | 4);
      chk("chroma_pe_cnt", n_pe, 8);
      chk("chroma_pe_order", order_err(16), 0);
      chk("chroma_wr_cnt", n_wr, 6);
      chk("chroma_abc_cnt", n_abc, 2);
      chk("chroma_seed_cnt", n_seed, 2);
      chk("chroma_done_cnt", n_done, 1);

      // Luma + chroma, reference trace for the stall and spurious runs.
      run_mb(1'b1, 1'b1, 0, 0, 0, 0, 0);
      chk("both_len", tr.size(), 119);
      chk("both_pe_cnt", n_pe, 24);
      chk("both_pe_order", order_err(0), 0);
      chk("both_abc_cnt", n_abc, 3);
      chk("both_wr_cnt", n_wr, 21);
      chk("both_done_cnt", n_done, 1);
      ref_tr = tr;

      // pe_done held high: one block per WAIT visit.
      run_mb(1'b1, 1'b1, 0, 1, 0, 0, 0);
      chk("hold_len", tr.size(), 95);
      chk("hold_pe_cnt", n_pe, 24);
      chk("hold_pe_order", order_err(0), 0);

      // ena toggling every cycle.
      run_mb(1'b1, 1'b1, 1, 0, 0, 0, 0);
      chk("stall_trace_diff", trace_diff(), 0);
      chk("stall_idle_strobes", idle_strobe, 0);

      // Spurious pe_done and start while busy.
      run_mb(1'b1, 1'b1, 0, 0, 1, 1, 0);
      chk("spurious_trace_diff", trace_diff(), 0);

      // Start with no plane flags.
      run_mb(1'b0, 1'b0, 0, 0, 0, 0, 0);
      chk("null_len", tr.size(), 1);
      chk("null_word", int'(tr[0]), 15'h0400);

      // Reset while blk 7 is in WAIT, then a clean luma run.
      run_mb(1'b1, 1'b0, 0, 0, 0, 0, 1);
      chk("abort_taken", int'(aborted), 1);
      chk("abort_no_done", n_done, 0);
      @(posedge clk); #1;
      chk("abort_held_outputs", int'(word()), 0);
      rst_n = 1'b1;
      run_mb(1'b1, 1'b0, 0, 0, 0, 0, 0);
      chk("post_abort_pe_cnt", n_pe, 16);
      chk("post_abort_pe_order", order_err(0), 0);
      chk("post_abort_done_cnt", n_done, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
